// File: rtl/io_defs_pkg.sv
// Shared IO-window definitions for the input conditioner and data memory IO decode.
// Latency: n/a (constants and a helper function only).
// Backpressure: n/a.
package io_defs;

   localparam int KEY_WIDTH          = 4;
   localparam int SW_WIDTH           = 10;
   localparam int IO_INPUT_BUS_WIDTH = 14;

   // Bit-field offsets inside io_input_bus; data_memory decodes with the same values.
   localparam int IO_KEY_LSB = 10;
   localparam int IO_SW_LSB  = 0;

   // Raw level a KEY pin shows when nobody is pressing it.
   function automatic logic key_idle_level(input int active_low);
      return (active_low != 0);
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: SYNC_STAGES-deep synchronizer, optional inversion, counter debouncer.
// Latency: raw edge to debounced change = SYNC_STAGES + DEBOUNCE_CYCLES cycles.
// Backpressure: none; free-running sampler.
module debounce_bit #(
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter int   SYNC_STAGES     = 2,
   parameter logic RESET_LEVEL     = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   input  logic invert,
   output logic debounced
);

   localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   s;

   // Synchronizer chain; resets to the idle pin level so release causes no false edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      end
   end

   // Polarity-normalised synchronized value; everything after this is active-high.
   assign s = sync_q[SYNC_STAGES-1] ^ invert;

   // Accept s only after DEBOUNCE_CYCLES consecutive cycles of disagreement with debounced.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q     <= '0;
         debounced <= 1'b0;
      end else if (s == debounced) begin
         cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
         debounced <= s;
         cnt_q     <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/io_input_conditioner.sv
// Conditions raw KEY/SW pins into the registered, active-high io_input_bus plus sticky key press flags.
// Latency: pin edge to io_input_bus = SYNC_STAGES + DEBOUNCE_CYCLES; key_event one cycle after that.
// Backpressure: none; key_event holds until software clears it, a same-cycle press wins over clear.
module io_input_conditioner
   import io_defs::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int SYNC_STAGES     = 2,
   parameter int KEY_ACTIVE_LOW  = 1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [KEY_WIDTH-1:0]          raw_key,
   input  logic [SW_WIDTH-1:0]           raw_sw,
   input  logic [KEY_WIDTH-1:0]          key_event_clear,
   output logic [IO_INPUT_BUS_WIDTH-1:0] io_input_bus,
   output logic [KEY_WIDTH-1:0]          key_event
);

   localparam logic KEY_IDLE   = key_idle_level(KEY_ACTIVE_LOW);
   localparam logic KEY_INVERT = (KEY_ACTIVE_LOW != 0);

   logic [KEY_WIDTH-1:0] key_d;
   logic [KEY_WIDTH-1:0] key_d_q;
   logic [KEY_WIDTH-1:0] key_press;
   logic [SW_WIDTH-1:0]  sw_d;

   genvar gi;

   generate
      for (gi = 0; gi < KEY_WIDTH; gi++) begin : g_key
         debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES),
            .RESET_LEVEL     (KEY_IDLE)
         ) u_db (
            .clock     (clock),
            .reset     (reset),
            .raw       (raw_key[gi]),
            .invert    (KEY_INVERT),
            .debounced (key_d[gi])
         );
      end
      for (gi = 0; gi < SW_WIDTH; gi++) begin : g_sw
         debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES),
            .RESET_LEVEL     (1'b0)
         ) u_db (
            .clock     (clock),
            .reset     (reset),
            .raw       (raw_sw[gi]),
            .invert    (1'b0),
            .debounced (sw_d[gi])
         );
      end
   endgenerate

   // Debounced values are already flop outputs, so the bus is registered with no extra stage.
   assign io_input_bus[IO_KEY_LSB +: KEY_WIDTH] = key_d;
   assign io_input_bus[IO_SW_LSB  +: SW_WIDTH]  = sw_d;

   // Rising edge of a debounced key; release edges are ignored.
   assign key_press = key_d & ~key_d_q;

   // Delayed debounced keys for edge detection, and sticky flags where set beats clear.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         key_d_q   <= '0;
         key_event <= '0;
      end else begin
         key_d_q   <= key_d;
         key_event <= (key_event & ~key_event_clear) | key_press;
      end
   end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2, active-low keys.
// Latency under test: 6 cycles pin to bus, 7 cycles pin to key_event.
// Backpressure: n/a.
module tb_io_input_conditioner;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  raw_key;
   logic [9:0]  raw_sw;
   logic [3:0]  key_event_clear;
   logic [13:0] io_input_bus;
   logic [3:0]  key_event;

   int n_checks = 0;
   int n_errors = 0;

   io_input_conditioner #(
      .DEBOUNCE_CYCLES (4),
      .SYNC_STAGES     (2),
      .KEY_ACTIVE_LOW  (1)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .raw_key         (raw_key),
      .raw_sw          (raw_sw),
      .key_event_clear (key_event_clear),
      .io_input_bus    (io_input_bus),
      .key_event       (key_event)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance one clock; drive and sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset           = 1'b0;
      raw_key         = 4'hF;
      raw_sw          = 10'h3FF;
      key_event_clear = 4'h0;

      // 1. reset state, then switches appear 6 cycles after release
      repeat (3) tick();
      check("rst_bus", 32'(io_input_bus), 32'h0);
      check("rst_evt", 32'(key_event), 32'h0);
      reset = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (i == 5) check("rel_sw_c5", 32'(io_input_bus[9:0]), 32'h0);
         if (i == 6) check("rel_sw_c6", 32'(io_input_bus[9:0]), 32'h3FF);
      end
      check("rel_keys_idle", 32'(io_input_bus[13:10]), 32'h0);
      raw_sw = 10'h000;
      repeat (8) tick();
      check("sw_cleared", 32'(io_input_bus), 32'h0);

      // 2. single switch latency, and a 3-cycle glitch that must be filtered
      raw_sw[0] = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (i == 5) check("sw0_c5", 32'(io_input_bus[0]), 32'h0);
         if (i == 6) check("sw0_c6", 32'(io_input_bus[0]), 32'h1);
      end
      raw_sw[1] = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         if (i == 4) raw_sw[1] = 1'b0;
         tick();
         check("sw1_glitch", 32'(io_input_bus[1]), 32'h0);
      end

      // 3. key 2 press, hold, release
      raw_key[2] = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         tick();
         if (i == 5) check("k2_c5", 32'(io_input_bus[12]), 32'h0);
         if (i == 6) check("k2_c6", 32'(io_input_bus[12]), 32'h1);
         if (i == 6) check("k2_evt_c6", 32'(key_event), 32'h0);
         if (i == 7) check("k2_evt_c7", 32'(key_event), 32'h4);
      end
      repeat (50) tick();
      check("k2_hold_bus", 32'(io_input_bus[13:10]), 32'h4);
      check("k2_hold_evt", 32'(key_event), 32'h4);
      raw_key[2] = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick();
         if (i == 5) check("k2_rel_c5", 32'(io_input_bus[12]), 32'h1);
         if (i == 6) check("k2_rel_c6", 32'(io_input_bus[12]), 32'h0);
      end
      check("k2_rel_evt", 32'(key_event), 32'h4);

      // 4. clear, and clear of an already-clear flag
      key_event_clear = 4'b0100;
      tick();
      key_event_clear = 4'b0000;
      check("clr_k2", 32'(key_event), 32'h0);
      key_event_clear = 4'b0001;
      tick();
      key_event_clear = 4'b0000;
      check("clr_idle", 32'(key_event), 32'h0);

      // 5. press edge and clear in the same cycle: set wins
      raw_key[1] = 1'b0;
      repeat (6) tick();
      check("k1_bus", 32'(io_input_bus[11]), 32'h1);
      check("k1_pre_evt", 32'(key_event), 32'h0);
      key_event_clear = 4'b0010;
      tick();
      key_event_clear = 4'b0000;
      check("k1_set_wins", 32'(key_event), 32'h2);
      raw_key[1] = 1'b1;
      repeat (8) tick();
      key_event_clear = 4'b0010;
      tick();
      key_event_clear = 4'b0000;
      check("k1_cleared", 32'(key_event), 32'h0);

      // 6. bouncing key 0, then a stable press yields exactly one event
      for (int c = 0; c < 20; c++) begin
         raw_key[0] = ((c / 2) % 2 == 1);
         tick();
      end
      check("k0_bounce_bus", 32'(io_input_bus[10]), 32'h0);
      check("k0_bounce_evt", 32'(key_event), 32'h0);
      raw_key[0] = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         tick();
         if (i == 5) check("k0_c5", 32'(io_input_bus[10]), 32'h0);
         if (i == 6) check("k0_c6", 32'(io_input_bus[10]), 32'h1);
         if (i == 6) check("k0_evt_c6", 32'(key_event), 32'h0);
         if (i == 7) check("k0_evt_c7", 32'(key_event), 32'h1);
      end
      repeat (10) tick();
      check("k0_single", 32'(key_event), 32'h1);
      key_event_clear = 4'b0001;
      tick();
      key_event_clear = 4'b0000;
      repeat (5) tick();
      check("k0_no_reevent", 32'(key_event), 32'h0);
      raw_key[0] = 1'b1;
      repeat (8) tick();
      check("k0_released", 32'(io_input_bus[13:10]), 32'h0);

      // mid-count reset on switch 5 must discard the partial count
      raw_sw[5] = 1'b1;
      repeat (4) tick();
      check("sw5_midcount", 32'(io_input_bus[5]), 32'h0);
      reset = 1'b0;
      #1;
      check("async_rst_bus", 32'(io_input_bus), 32'h0);
      check("async_rst_evt", 32'(key_event), 32'h0);
      repeat (2) tick();
      reset = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (i <= 5) check("sw5_after_rst", 32'(io_input_bus[5]), 32'h0);
         if (i == 6) check("sw5_full_count", 32'(io_input_bus[5]), 32'h1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/io_input_conditioner.md
Name: io_input_conditioner

Overview:
Upstream of the core's io_input_bus. Conditions the raw DE-board KEY[3:0] and SW[9:0] pins into the 14-bit io_input_bus read by the data memory's memory-mapped IO window. Per-bit processing is a synchronizer, then a counter-based debouncer, then KEY polarity normalisation. Also provides sticky per-key press-event flags that software clears through a write strobe.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive cycles a synchronized input must differ from its debounced value before it is accepted (1 ms at 50 MHz); legal range >= 1.
SYNC_STAGES, 2, synchronizer flop depth per input bit; legal range >= 2.
KEY_ACTIVE_LOW, 1, 1 = raw KEY pins read 0 when pressed; outputs are always active-high.

Ports:
clock  input  1  core clock
reset  input  1  asynchronous, active-low reset
raw_key  input  4  asynchronous KEY pins
raw_sw  input  10  asynchronous SW pins
key_event_clear  input  4  one-cycle strobe; bit i clears key_event[i]
io_input_bus  output  14  {debounced KEY pressed[3:0], debounced SW[9:0]}, active-high
key_event  output  4  sticky press flags, one per KEY

Behaviour:
- Reset: while reset=0, asynchronously:
  - all synchronizer flops take the idle raw level: KEY = 1 if KEY_ACTIVE_LOW else 0; SW = 0.
  - debounced state = 0, counters = 0, io_input_bus = 14'b0, key_event = 4'b0.
- Reset release: the first rising clock edge with reset=1 starts normal operation. A reset asserted mid-count discards the partial count.
- Synchronizer: SYNC_STAGES flops per bit. Nothing downstream reads the raw pins.
- Normalisation: KEY bits are inverted after the last synchronizer stage when KEY_ACTIVE_LOW=1. All later logic is active-high.
- Debounce, per bit, with s = normalised synced value, d = debounced value, cnt of width $clog2(DEBOUNCE_CYCLES+1):
  - if s == d: cnt <= 0.
  - else if cnt == DEBOUNCE_CYCLES-1: d <= s, cnt <= 0.
  - else: cnt <= cnt+1.
- Debounce consequences:
  - A change is accepted after exactly DEBOUNCE_CYCLES consecutive differing cycles.
  - Any shorter pulse or glitch returns cnt to 0 and d never changes.
  - Counters never wrap.
  - With DEBOUNCE_CYCLES=1, d follows s one cycle later.
- Latency: raw pin edge to io_input_bus change = SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- io_input_bus is registered (it is d directly). Bit order: [13:10]=KEY[3:0], [9:0]=SW[9:0].
- Event flags, per KEY i:
  - press edge = d_key[i] goes 0->1, detected from a registered copy of d, so it is visible one cycle after io_input_bus[10+i] rises.
  - key_event[i] sets on a press edge and holds until key_event_clear[i].
  - Press edge and clear in the same cycle: set wins, so no event is lost.
  - Clear with the flag already 0: no effect.
  - Release edges produce no event.
  - Holding a key produces a single event.
- Bits are independent. Simultaneous transitions on several bits debounce in parallel, with no interaction between bits.
- No combinational path exists from any input to any output.

Decomposition:
- Shared package io_defs:
  - KEY_WIDTH=4, SW_WIDTH=10, IO_INPUT_BUS_WIDTH=14.
  - Bit-field offsets IO_KEY_LSB=10, IO_SW_LSB=0, shared with data_memory's IO decode.
- Sub-module debounce_bit(clock, reset, raw, invert, debounced), parameterised by DEBOUNCE_CYCLES, SYNC_STAGES and reset level. It contains the synchronizer and counter and is instantiated 14 times via generate.
- The top level holds normalisation wiring, the press-edge registers and the event flags.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, KEY_ACTIVE_LOW=1):
1. Hold reset=0 with raw_key=4'hF, raw_sw=10'h3FF; release. io_input_bus=0 and key_event=0 during reset; SW bits become 10'h3FF exactly 6 cycles after release.
2. raw_sw[0] 0->1 held. io_input_bus[0] rises exactly 6 cycles after the edge; a 3-cycle 0->1->0 pulse on raw_sw[1] leaves io_input_bus[1]=0 throughout.
3. raw_key[2] driven to 0 and held. io_input_bus[12] = 1 after 6 cycles; key_event = 4'b0100 one cycle later; holding the key 50 cycles yields no further change; releasing it gives io_input_bus[12]=0 6 cycles later, and key_event stays 4'b0100.
4. With key_event=4'b0100, pulse key_event_clear=4'b0100. key_event = 0 next cycle; a clear of 4'b0001 with the flag already 0 leaves it 0.
5. Arrange a key_event[1] press edge in the same cycle as key_event_clear[1]=1. key_event[1] = 1 after that cycle (set wins).
6. Bounce raw_key[0] low/high every 2 cycles for 20 cycles, then hold it low. Exactly one key_event[0] set, occurring 6+1 cycles after the final stable edge; assert reset=0 mid-count on another bit and its output stays 0 after release.
